// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: request/response channels of two requesters plus the shared RAM port.
// The slave modport is the arbiter's view; master is the complementary client/RAM side.
interface sram_port_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          r0_valid;
    logic          r0_ready;
    logic          r0_we;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_rvalid;
    logic [DW-1:0] r0_rdata;
    logic          r1_valid;
    logic          r1_ready;
    logic          r1_we;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_rvalid;
    logic [DW-1:0] r1_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  r0_valid, r0_we, r0_addr, r0_wdata,
        output r0_ready, r0_rvalid, r0_rdata,
        input  r1_valid, r1_we, r1_addr, r1_wdata,
        output r1_ready, r1_rvalid, r1_rdata,
        output ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output r0_valid, r0_we, r0_addr, r0_wdata,
        input  r0_ready, r0_rvalid, r0_rdata,
        output r1_valid, r1_we, r1_addr, r1_wdata,
        input  r1_ready, r1_rvalid, r1_rdata,
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: grants one of two requesters per cycle onto a single-port RAM, registered read return.
// Define ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 wins contention); default is round-robin.
module sram_port_arbiter #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_port_arbiter_if.slave bus
);
    logic          w_g0;
    logic          w_g1;
    logic          w_rd0;
    logic          w_rd1;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

`ifdef ARB_FIXED_PRIORITY_EN
    assign w_g0 = rst_n && bus.r0_valid;
    assign w_g1 = rst_n && bus.r1_valid && !bus.r0_valid;
`else
    logic r_last_grant;
    // Under contention the requester that was not granted last wins.
    assign w_g0 = rst_n && bus.r0_valid && (!bus.r1_valid || r_last_grant);
    assign w_g1 = rst_n && bus.r1_valid && (!bus.r0_valid || !r_last_grant);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last_grant <= 1'b1;
        else if (w_g0 || w_g1)
            r_last_grant <= w_g1;
    end
`endif

    assign w_rd0   = w_g0 && !bus.r0_we;
    assign w_rd1   = w_g1 && !bus.r1_we;
    assign w_addr  = w_g0 ? bus.r0_addr  : w_g1 ? bus.r1_addr  : '0;
    assign w_wdata = w_g0 ? bus.r0_wdata : w_g1 ? bus.r1_wdata : '0;

    assign bus.r0_ready  = w_g0;
    assign bus.r1_ready  = w_g1;
    assign bus.ram_we    = (w_g0 && bus.r0_we) || (w_g1 && bus.r1_we);
    assign bus.ram_addr  = w_addr;
    assign bus.ram_wdata = w_wdata;
    assign bus.r0_rvalid = r_rvalid0;
    assign bus.r1_rvalid = r_rvalid1;
    assign bus.r0_rdata  = r_rdata0;
    assign bus.r1_rdata  = r_rdata1;

    // RAM read is combinational, so the accepting edge captures the addressed word directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_rd0;
            r_rvalid1 <= w_rd1;
            if (w_rd0)
                r_rdata0 <= bus.ram_rdata;
            if (w_rd1)
                r_rdata1 <= bus.ram_rdata;
        end
    end
endmodule
